// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: shared types and constants for the UART bus slave.
//   state_e        - access FSM states (IDLE, WAIT_TX, RESP)
//   ADDR_*         - word offsets of the DATA / STATUS / CTRL registers
//   ST_*           - bit positions inside the STATUS read value
//   ST_CTRL_LSB    - lowest bit of the CTRL mirror inside STATUS
//   RX_EMPTY_FLAG  - bit set in a DATA load when the RX FIFO was empty
package uart_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_TX = 2'd1,
    RESP    = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_RX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_DROP    = 2;
  localparam int ST_CTRL_LSB   = 3;

  localparam int RX_EMPTY_FLAG = 8;

endpackage

// File: rtl/uart_bus_if.sv
// uart_bus_if: memory-mapped slave between the core data port and the UART
// top block. Loads/stores become rd_uart/wr_uart pulses; DATA, STATUS and
// CTRL registers are exposed; a registered level interrupt is generated.
//
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-low reset
//   sel, we, addr,    - bus request; held stable until ready
//   wdata
//   rdata, ready      - load data and one-cycle completion strobe
//   irq               - level interrupt (registered)
//   rx_empty, tx_full - UART FIFO flags
//   r_data            - RX FIFO head
//   rd_uart, wr_uart  - RX pop / TX push pulses
//   w_data            - TX byte, valid with wr_uart
//
// Optional: define UART_BUS_TIMEOUT_EN to bound the stall on a DATA store
// while the TX FIFO is full (TIMEOUT cycles); the byte is then dropped and
// the sticky tx_drop status bit is set.
module uart_bus_if
  import uart_bus_pkg::*;
#(
  parameter int          DBIT    = 8,
  parameter int          DW      = 32,
  parameter int unsigned TIMEOUT = 1024,
  parameter int          TO_BIT  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata,
  output logic            ready,
  output logic            irq,
  input  logic            rx_empty,
  input  logic            tx_full,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data
);

  state_e            state_q, state_d;
  logic              pop_q, pop_d;     // RESP must pop the RX FIFO
  logic              push_q, push_d;   // RESP must push the TX FIFO
  logic [DBIT-1:0]   w_data_q, w_data_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        ctrl_q, ctrl_d;   // [0] rx_irq_en, [1] tx_irq_en
  logic              irq_q;
  logic              tx_drop;

`ifdef UART_BUS_TIMEOUT_EN
  logic              tx_drop_q, tx_drop_d;
  logic [TO_BIT-1:0] cnt_q, cnt_d;
  assign tx_drop = tx_drop_q;
`else
  assign tx_drop = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, TO_BIT};
`endif

  logic unused_wdata;
  assign unused_wdata = ^wdata[DW-1:DBIT];

  always_comb begin
    state_d  = state_q;
    pop_d    = pop_q;
    push_d   = push_q;
    w_data_d = w_data_q;
    rdata_d  = rdata_q;
    ctrl_d   = ctrl_q;
`ifdef UART_BUS_TIMEOUT_EN
    tx_drop_d = tx_drop_q;
    cnt_d     = cnt_q;
`endif
    ready   = 1'b0;
    rd_uart = 1'b0;
    wr_uart = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel) begin
          pop_d   = 1'b0;
          push_d  = 1'b0;
          rdata_d = '0;
          case (addr)
            ADDR_DATA: begin
              if (we) begin
                w_data_d = wdata[DBIT-1:0];
                push_d   = 1'b1;
              end else if (!rx_empty) begin
                rdata_d = {{(DW-DBIT){1'b0}}, r_data};
                pop_d   = 1'b1;
              end else begin
                rdata_d[RX_EMPTY_FLAG] = 1'b1;
              end
            end
            ADDR_STATUS: begin
              if (we) begin
`ifdef UART_BUS_TIMEOUT_EN
                if (wdata[ST_TX_DROP]) tx_drop_d = 1'b0;
`endif
              end else begin
                rdata_d[ST_RX_EMPTY]        = rx_empty;
                rdata_d[ST_TX_FULL]         = tx_full;
                rdata_d[ST_TX_DROP]         = tx_drop;
                rdata_d[ST_CTRL_LSB +: 2]   = ctrl_q;
              end
            end
            ADDR_CTRL: begin
              if (we) ctrl_d = wdata[1:0];
              else    rdata_d[1:0] = ctrl_q;
            end
            default: ;  // reserved: load reads 0, store ignored
          endcase
`ifdef UART_BUS_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = (we && (addr == ADDR_DATA) && tx_full) ? WAIT_TX : RESP;
        end
      end
      WAIT_TX: begin
        // A free slot on the timeout cycle still wins over the drop.
        if (!tx_full) begin
          state_d = RESP;
        end
`ifdef UART_BUS_TIMEOUT_EN
        else if (cnt_q == TO_BIT'(TIMEOUT - 1)) begin
          push_d    = 1'b0;
          tx_drop_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        ready   = 1'b1;
        rd_uart = pop_q;
        wr_uart = push_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pop_q    <= 1'b0;
      push_q   <= 1'b0;
      w_data_q <= '0;
      rdata_q  <= '0;
      ctrl_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      w_data_q <= w_data_d;
      rdata_q  <= rdata_d;
      ctrl_q   <= ctrl_d;
      irq_q    <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & ~tx_full);
    end
  end

`ifdef UART_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_drop_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      tx_drop_q <= tx_drop_d;
      cnt_q     <= cnt_d;
    end
  end
`endif

  assign rdata  = rdata_q;
  assign w_data = w_data_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_uart_bus_if.sv
// tb_uart_bus_if: directed scoreboard bench for uart_bus_if. Each access
// pushes its expected response; a negedge monitor pops and compares
// whenever ready is seen. Build with UART_BUS_TIMEOUT_EN to also exercise
// the TX timeout path (TIMEOUT=16 here).
module tb_uart_bus_if;

  localparam int DBIT = 8;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            sel = 1'b0;
  logic            we = 1'b0;
  logic [1:0]      addr = 2'd0;
  logic [DW-1:0]   wdata = '0;
  logic [DW-1:0]   rdata;
  logic            ready;
  logic            irq;
  logic            rx_empty = 1'b1;
  logic            tx_full = 1'b0;
  logic [DBIT-1:0] r_data = '0;
  logic            rd_uart;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;

  uart_bus_if #(.DBIT(DBIT), .DW(DW), .TIMEOUT(16), .TO_BIT(5)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .irq(irq),
    .rx_empty(rx_empty), .tx_full(tx_full), .r_data(r_data),
    .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        wr;
    logic [7:0]  wd;
    logic        pop;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   wr_pulses = 0;
  int   txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (wr_uart) wr_pulses++;
      if (ready) begin
        txn++;
        $display("txn %0d: rdata=0x%08h wr_uart=%0b w_data=0x%02h rd_uart=%0b",
                 txn, rdata, wr_uart, w_data, rd_uart);
        if (sb.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_ready: got ready=1, expected no response");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk_rd) chk("rdata", rdata, e.rd);
          chk("wr_uart", {31'd0, wr_uart}, {31'd0, e.wr});
          if (e.wr) chk("w_data", {24'd0, w_data}, {24'd0, e.wd});
          chk("rd_uart", {31'd0, rd_uart}, {31'd0, e.pop});
        end
      end else if (wr_uart || rd_uart) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL stray_strobe: got wr=%0b rd=%0b with ready=0, expected none",
                 wr_uart, rd_uart);
      end
    end
  end

  task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic chk_rd, input logic [31:0] erd,
                        input logic ewr, input logic [7:0] ewd, input logic epop,
                        input int exp_lat);
    exp_t e;
    int   lat;
    logic got;
    e.chk_rd = chk_rd; e.rd = erd; e.wr = ewr; e.wd = ewd; e.pop = epop;
    sb.push_back(e);
    @(posedge clk); #1;
    sel = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (ready) got = 1'b1;
    end
    if (!got) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL ready_timeout: got no ready in %0d cycles, expected ready", lat);
    end else begin
      chk("latency", lat, exp_lat);
    end
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    #3;
    // Reset state
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wr", {31'd0, wr_uart}, 32'd0);
    chk("rst_rd", {31'd0, rd_uart}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // DATA store, FIFO not full: exactly one push
    p0 = wr_pulses;
    access(1'b1, 2'd0, 32'h0000_0041, 1'b0, 32'd0, 1'b1, 8'h41, 1'b0, 2);
    chk("one_push", wr_pulses - p0, 1);

    // DATA load with data, then with empty FIFO
    rx_empty = 1'b0; r_data = 8'h5A;
    access(1'b0, 2'd0, 32'd0, 1'b1, 32'h0000_005A, 1'b0, 8'h00, 1'b1, 2);
    rx_empty = 1'b1;
    access(1'b0, 2'd0, 32'd0, 1'b1, 32'h0000_0100, 1'b0, 8'h00, 1'b0, 2);

    // CTRL write/read, STATUS read with ctrl mirror
    access(1'b1, 2'd2, 32'hFFFF_FFF3, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 2);
    access(1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0003, 1'b0, 8'h00, 1'b0, 2);
    access(1'b0, 2'd1, 32'd0, 1'b1, 32'h0000_0019, 1'b0, 8'h00, 1'b0, 2);

    // Reserved offset
    access(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 2);
    access(1'b0, 2'd3, 32'd0, 1'b1, 32'h0000_0000, 1'b0, 8'h00, 1'b0, 2);
    access(1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0003, 1'b0, 8'h00, 1'b0, 2);

    // Store stalled by a full TX FIFO for 20 cycles
    tx_full = 1'b1;
    fork
      access(1'b1, 2'd0, 32'h0000_0033, 1'b0, 32'd0, 1'b1, 8'h33, 1'b0, 22);
      begin
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1 tx_full = 1'b0;
      end
    join

    // RX interrupt
    access(1'b1, 2'd2, 32'h0000_0001, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 2);
    rx_empty = 1'b0;
    @(negedge clk);
    chk("irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rx", {31'd0, irq}, 32'd1);
    r_data = 8'h11;
    access(1'b0, 2'd0, 32'd0, 1'b1, 32'h0000_0011, 1'b0, 8'h00, 1'b1, 2);
    rx_empty = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_drained", {31'd0, irq}, 32'd0);
    access(1'b1, 2'd2, 32'h0000_0000, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 2);
    rx_empty = 1'b0;
    repeat (3) @(negedge clk);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rx_empty = 1'b1;

`ifdef UART_BUS_TIMEOUT_EN
    // Timeout drop with tx_full stuck
    tx_full = 1'b1;
    p0 = wr_pulses;
    access(1'b1, 2'd0, 32'h0000_0055, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 18);
    chk("drop_no_push", wr_pulses - p0, 0);
    access(1'b0, 2'd1, 32'd0, 1'b1, 32'h0000_0007, 1'b0, 8'h00, 1'b0, 2);
    access(1'b1, 2'd1, 32'h0000_0004, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 2);
    access(1'b0, 2'd1, 32'd0, 1'b1, 32'h0000_0003, 1'b0, 8'h00, 1'b0, 2);
    tx_full = 1'b0;
`endif

    // Reset while stalled in WAIT_TX
    access(1'b1, 2'd2, 32'h0000_0002, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 2);
    access(1'b0, 2'd0, 32'd0, 1'b1, 32'h0000_0100, 1'b0, 8'h00, 1'b0, 2);
    tx_full = 1'b1;
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h0000_0077;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_wdata", {24'd0, w_data}, 32'd0);
    chk("arst_wr", {31'd0, wr_uart}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    sel = 1'b0; we = 1'b0;
    tx_full = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    p0 = wr_pulses;
    repeat (5) @(posedge clk);
    chk("no_push_after_rst", wr_pulses - p0, 0);
    access(1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0000, 1'b0, 8'h00, 1'b0, 2);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
